// File: rtl/kg_rs232_pkg.sv
// Shared Keyless-Go RS232 receive definitions.
// Telegram framing constants and the receive FSM state type.
package kg_rs232_pkg;

  localparam int         TEL_LEN     = 11;
  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         RN_IDX      = 2;
  localparam int         TIMEOUT_CYC = 50000;

  // rst_ctrl's completion compare value
  localparam logic [3:0] TEL_DONE_CNT = 4'(TEL_LEN);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;

endpackage

// File: rtl/telegram_buffer_byte_timeout_timer.sv
// Inter-byte idle counter for telegram reception.
// Saturating; expiry holds until cleared by a byte or leaving COLLECT.
module byte_timeout_timer #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_run,
  output logic o_expired
);

  localparam int            TW    = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] SAT   = '1;

  logic [TW-1:0] r_timer;

  always_ff @(posedge clk) begin
    if (rst)
      r_timer <= '0;
    else if (i_clr)
      r_timer <= '0;
    else if (i_run && r_timer != SAT)
      r_timer <= r_timer + TW'(1);
  end

  assign o_expired = (r_timer >= LIMIT);

endmodule

// File: rtl/telegram_buffer.sv
// Frames UART bytes into Keyless-Go telegrams and validates them.
// Publishes byte count, repetition number and the stored payload.
module telegram_buffer
  import kg_rs232_pkg::*;
#(
  parameter int         TEL_LEN     = kg_rs232_pkg::TEL_LEN,
  parameter logic [7:0] SYNC_BYTE   = kg_rs232_pkg::SYNC_BYTE,
  parameter int         RN_IDX      = kg_rs232_pkg::RN_IDX,
  parameter int         TIMEOUT_CYC = kg_rs232_pkg::TIMEOUT_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_err,
  output logic [7:0] crn,
  output logic [3:0] cnt,
  output logic       tel_ok,
  output logic       tel_err,
  input  logic [3:0] rd_idx,
  output logic [7:0] rd_data
);

  localparam logic [3:0] LAST = 4'(TEL_LEN - 1);
  localparam logic [3:0] FULL = 4'(TEL_LEN);

  state_t     r_state, w_state_nx;
  logic [3:0] r_cnt, w_cnt_nx;
  logic [7:0] r_xor, w_xor_nx;
  logic [7:0] r_crn, w_crn_nx;
  logic       r_ok, w_ok_nx;
  logic       r_err, w_err_nx;
  logic       w_wr;
  logic [3:0] w_wr_idx;
  logic       w_expired;
  logic [7:0] r_buf [TEL_LEN];

  byte_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (rx_valid | (r_state != COLLECT)),
    .i_run    (r_state == COLLECT),
    .o_expired(w_expired)
  );

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_xor_nx   = r_xor;
    w_crn_nx   = r_crn;
    w_ok_nx    = 1'b0;
    w_err_nx   = 1'b0;
    w_wr       = 1'b0;
    w_wr_idx   = 4'd0;
    unique case (r_state)
      COLLECT: begin
        // rx_err beats a same-cycle byte; a byte beats timeout
        if (rx_err) begin
          w_state_nx = IDLE;
          w_cnt_nx   = 4'd0;
          w_err_nx   = 1'b1;
        end else if (rx_valid) begin
          w_wr     = 1'b1;
          w_wr_idx = r_cnt;
          if (r_cnt == LAST) begin
            if (rx_data == r_xor) begin
              w_state_nx = DONE;
              w_cnt_nx   = FULL;
              w_crn_nx   = r_buf[RN_IDX];
              w_ok_nx    = 1'b1;
            end else begin
              w_state_nx = IDLE;
              w_cnt_nx   = 4'd0;
              w_err_nx   = 1'b1;
            end
          end else begin
            w_xor_nx = r_xor ^ rx_data;
            w_cnt_nx = r_cnt + 4'd1;
          end
        end else if (w_expired) begin
          w_state_nx = IDLE;
          w_cnt_nx   = 4'd0;
          w_err_nx   = 1'b1;
        end
      end
      default: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          w_wr       = 1'b1;
          w_state_nx = COLLECT;
          w_cnt_nx   = 4'd1;
          w_xor_nx   = SYNC_BYTE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_xor   <= 8'h00;
      r_crn   <= 8'h00;
      r_ok    <= 1'b0;
      r_err   <= 1'b0;
      for (int i = 0; i < TEL_LEN; i++)
        r_buf[i] <= 8'h00;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_xor   <= w_xor_nx;
      r_crn   <= w_crn_nx;
      r_ok    <= w_ok_nx;
      r_err   <= w_err_nx;
      if (w_wr)
        r_buf[w_wr_idx] <= rx_data;
    end
  end

  assign cnt     = r_cnt;
  assign crn     = r_crn;
  assign tel_ok  = r_ok;
  assign tel_err = r_err;
  assign rd_data = (rd_idx < FULL) ? r_buf[rd_idx] : 8'h00;

endmodule

// File: tb/tb_telegram_buffer.sv
// Scoreboard bench for telegram_buffer.
// Expected completions are queued by stimulus, checked by a monitor.
module tb_telegram_buffer;

  localparam int T = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic [7:0] crn;
  logic [3:0] cnt;
  logic       tel_ok;
  logic       tel_err;
  logic [3:0] rd_idx;
  logic [7:0] rd_data;

  typedef struct {
    bit         ok;
    logic [3:0] cnt;
    logic [7:0] crn;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  logic [7:0] m_crn = 8'h00;

  telegram_buffer #(
    .TIMEOUT_CYC(T)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_err  (rx_err),
    .crn     (crn),
    .cnt     (cnt),
    .tel_ok  (tel_ok),
    .tel_err (tel_err),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: every pulse must match the next queued expectation
  always @(negedge clk) begin
    if (tel_ok === 1'b1 || tel_err === 1'b1) begin
      n_chk++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: ok=%b err=%b", tel_ok, tel_err);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (tel_ok !== e.ok || tel_err !== !e.ok ||
            cnt !== e.cnt || crn !== e.crn) begin
          n_err++;
          $display("FAIL pulse: got ok=%b err=%b cnt=%0d crn=%h want ok=%b cnt=%0d crn=%h",
                   tel_ok, tel_err, cnt, crn, e.ok, e.cnt, e.crn);
        end
      end
    end
  end

  task automatic send(logic [7:0] b, int idle);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (idle) @(negedge clk);
  endtask

  task automatic push(bit ok);
    exp_t e;
    e.ok  = ok;
    e.cnt = ok ? 4'd11 : 4'd0;
    e.crn = m_crn;
    q.push_back(e);
  endtask

  // Sends a full 11-byte frame; bad flips the checksum LSB
  task automatic send_frame(logic [7:0] rn, bit bad, int spacing);
    logic [7:0] f [11];
    logic [7:0] prev;
    f[0] = 8'hA5;
    f[1] = 8'h01;
    f[2] = rn;
    for (int i = 3; i < 10; i++) f[i] = 8'h00;
    f[10] = (8'hA5 ^ 8'h01 ^ rn) ^ (bad ? 8'h01 : 8'h00);
    prev = m_crn;
    for (int i = 0; i < 10; i++) begin
      send(f[i], spacing == 0 ? 0 : i % spacing);
      chk("cnt_step", {4'h0, cnt}, 8'(i + 1));
      chk("crn_hold", crn, prev);
    end
    if (!bad) m_crn = rn;
    push(!bad);
    send(f[10], 0);
    chk("cnt_final", {4'h0, cnt}, bad ? 8'd0 : 8'd11);
    chk("crn_final", crn, m_crn);
  endtask

  initial begin
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    rd_idx   = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_cnt", {4'h0, cnt}, 8'd0);
    chk("rst_crn", crn, 8'h00);
    chk("rst_pulses", {6'd0, tel_ok, tel_err}, 8'd0);
    chk("rst_rd", rd_data, 8'h00);

    // noise before any sync is ignored
    send(8'h3C, 0);
    chk("idle_noise", {4'h0, cnt}, 8'd0);

    // good frame with varied spacing
    send_frame(8'h07, 1'b0, 3);
    rd_idx = 4'd2;  #1 chk("rd_rn", rd_data, 8'h07);
    rd_idx = 4'd10; #1 chk("rd_cs", rd_data, 8'hA3);
    rd_idx = 4'd11; #1 chk("rd_oob11", rd_data, 8'h00);
    rd_idx = 4'd15; #1 chk("rd_oob15", rd_data, 8'h00);
    rd_idx = 4'd2;
    send(8'h42, 1);
    chk("done_noise", {4'h0, cnt}, 8'd11);

    // bad checksum keeps crn
    send_frame(8'h07, 1'b1, 0);
    send(8'h00, 0);
    chk("bad_idle", {4'h0, cnt}, 8'd0);

    // byte on the expiry cycle keeps collecting
    send(8'hA5, 0);
    send(8'h01, T - 1);
    chk("pre_expiry", {4'h0, cnt}, 8'd2);
    send(8'h05, 0);
    chk("expiry_byte", {4'h0, cnt}, 8'd3);
    // then a real timeout
    push(1'b0);
    repeat (T + 2) @(negedge clk);
    chk("timeout_cnt", {4'h0, cnt}, 8'd0);

    // rx_err after 5 bytes, with a discarded byte alongside
    send(8'hA5, 0);
    send(8'h01, 0);
    send(8'h08, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    push(1'b0);
    rx_err   = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    @(negedge clk);
    rx_err   = 1'b0;
    rx_valid = 1'b0;
    chk("rxerr_cnt", {4'h0, cnt}, 8'd0);
    send(8'h00, 0);
    send(8'h11, 0);
    chk("rxerr_noise", {4'h0, cnt}, 8'd0);
    send_frame(8'h08, 1'b0, 0);

    // back-to-back good frames
    send_frame(8'h07, 1'b0, 0);
    send_frame(8'h09, 1'b0, 0);
    chk("b2b_rd", rd_data, 8'h09);

    // reset mid-frame
    send(8'hA5, 0);
    for (int i = 0; i < 5; i++) send(8'h01, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_crn = 8'h00;
    chk("mrst_cnt", {4'h0, cnt}, 8'd0);
    chk("mrst_crn", crn, 8'h00);
    chk("mrst_pulses", {6'd0, tel_ok, tel_err}, 8'd0);
    chk("mrst_rd", rd_data, 8'h00);
    send(8'h11, 0);
    send(8'h22, 0);
    chk("mrst_noise", {4'h0, cnt}, 8'd0);

    repeat (3) @(negedge clk);
    chk("queue_empty", 8'(q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/telegram_buffer.md
Name: telegram_buffer

Overview:
Receive-side buffer between the RS232 UART receiver and rst_ctrl. It frames the incoming byte stream into fixed-length Keyless-Go telegrams and validates each frame by sync byte, XOR checksum and inter-byte timeout. It publishes the running receive count (cnt) and the telegram repetition number (crn) that rst_ctrl compares against the generator's rn. A read port exposes the stored payload to downstream HIL logic.

Parameters:
TEL_LEN, 11, telegram length in bytes including sync and checksum (must be 3..15)
SYNC_BYTE, 8'hA5, byte value that opens a telegram
RN_IDX, 2, byte index of the repetition number within the telegram
TIMEOUT_CYC, 50000, maximum idle clk cycles between bytes inside a telegram

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
rx_data  input  8  byte from UART receiver
rx_valid  input  1  one-cycle strobe, rx_data valid
rx_err  input  1  one-cycle UART framing/parity error strobe
crn  output  8  repetition number of last good telegram
cnt  output  4  bytes received in current telegram; holds TEL_LEN after a good telegram
tel_ok  output  1  one-cycle pulse, good telegram completed
tel_err  output  1  one-cycle pulse, telegram aborted (checksum, rx_err or timeout)
rd_idx  input  4  payload read index
rd_data  output  8  stored byte at rd_idx, combinational from buffer; 0 if rd_idx >= TEL_LEN

Behaviour:
- Reset (synchronous, active-high, on clk edge with rst=1): state IDLE; cnt=0, crn=0, tel_ok=0, tel_err=0, buffer all 0, timer 0, running XOR 0. rst overrides all other inputs that cycle.
- States: IDLE, COLLECT, DONE.
- IDLE/DONE: rx_valid with rx_data==SYNC_BYTE -> store at index 0, cnt=1, xor=SYNC_BYTE, timer=0, go COLLECT. Other bytes and rx_err are ignored; cnt holds (0 in IDLE, TEL_LEN in DONE).
- COLLECT, byte arrives with cnt < TEL_LEN-1: store at index cnt, xor ^= byte, cnt++, timer=0. SYNC_BYTE value mid-frame is treated as data.
- COLLECT, last byte (cnt == TEL_LEN-1): compare byte with running xor.
  - Match: cnt=TEL_LEN, crn=buffer[RN_IDX], tel_ok=1 next cycle, go DONE.
  - Mismatch: cnt=0, crn unchanged, tel_err=1 next cycle, go IDLE.
- COLLECT, no rx_valid: timer++. When timer reaches TIMEOUT_CYC-1: cnt=0, tel_err=1, go IDLE.
- COLLECT, rx_err: cnt=0, tel_err=1, go IDLE; a byte in the same cycle is discarded.
- Simultaneous rx_valid and timeout expiry: the byte wins, timer clears.
- crn changes only on a good-telegram completion, never mid-frame, so rst_ctrl never compares against a partial value.
- Latency: cnt/crn/tel_ok update on the clk edge that samples the final byte's rx_valid; outputs are visible the following cycle.
- Buffer contents persist after an abort until overwritten. rd_data for a good telegram remains stable in DONE until the next sync byte.
- Timer width: clog2(TIMEOUT_CYC)+1, saturating, no wrap. cnt never exceeds TEL_LEN.

Decomposition:
- Shared package kg_rs232_pkg: state enum (IDLE/COLLECT/DONE), SYNC_BYTE, TEL_LEN, RN_IDX; rst_ctrl's completion compare (4'b1011) derives from the same TEL_LEN.
- One natural sub-module, byte_timeout_timer: counts clk, clears on rx_valid, reports expiry. Everything else stays flat.

Test Plan:
- Good frame: A5 01 07 00×7 A3 at any byte spacing -> cnt steps 1..10 then 11, crn=8'h07, one tel_ok pulse, rd_idx=2 gives 07.
- Bad checksum: same frame with last byte A2 -> cnt goes 0, crn keeps its previous value, one tel_err pulse, state IDLE.
- Timeout: A5 01 then no byte for TIMEOUT_CYC cycles -> tel_err pulse, cnt=0. A byte arriving on the expiry cycle instead -> collection continues.
- rx_err mid-frame after 5 bytes -> cnt=0, tel_err. Following noise bytes 00 11 are ignored. A new good frame with rn=08 -> crn=08.
- Back-to-back frames: good frame (rn=07), then immediately A5 ... with rn=09 -> cnt goes 11 -> 1, crn stays 07 until the second checksum passes, then becomes 09.
- rst asserted mid-frame after 6 bytes -> next cycle cnt=0, crn=0, no pulses, IDLE. Non-sync bytes are then ignored.
